// File: rtl/raster_block_reorder_if.sv
// Stream bundle for the block-to-raster reorder stage: slice control,
// block input handshake and raster beat output handshake.
interface raster_block_reorder_if #(
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int BLK_H           = 2,
  parameter int BLK_W           = 8,
  parameter int NUM_CP          = 3,
  parameter int BPC             = 14,
  parameter int OUT_PIX         = 4
);
  localparam int WW    = $clog2(MAX_SLICE_WIDTH + 1);
  localparam int IN_W  = NUM_CP * BLK_H * BLK_W * BPC;
  localparam int OUT_W = OUT_PIX * NUM_CP * BPC;

  logic             sof;
  logic [WW-1:0]    slice_width;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;

  // master: upstream producer plus downstream consumer
  modport master (
    output sof, slice_width, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol
  );

  // slave: the reorder stage itself
  modport slave (
    input  sof, slice_width, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/raster_block_reorder.sv
// Reorders BLK_H x BLK_W pixel blocks into raster lines, OUT_PIX pixels per
// beat. Two banks of BLK_H row RAMs: one bank fills while the other drains.
module raster_block_reorder #(
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int BLK_H           = 2,
  parameter int BLK_W           = 8,
  parameter int NUM_CP          = 3,
  parameter int BPC             = 14,
  parameter int OUT_PIX         = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  raster_block_reorder_if.slave bus
);
  localparam int PIX_W    = NUM_CP * BPC;
  localparam int WORD_W   = BLK_W * PIX_W;
  localparam int BEAT_W   = OUT_PIX * PIX_W;
  localparam int MAX_BLKS = (MAX_SLICE_WIDTH + BLK_W - 1) / BLK_W;
  localparam int AW       = (MAX_BLKS > 1) ? $clog2(MAX_BLKS) : 1;
  localparam int BPW      = BLK_W / OUT_PIX;
  localparam int BW       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int RW       = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DONE = 2'd2} rd_state_t;

  logic              started_reg;
  logic [AW-1:0]     last_blk_reg, last_blk_next;
  logic [BW-1:0]     last_beat_reg, last_beat_next;
  logic [AW-1:0]     blk_cnt_reg;
  logic              wr_bank_reg, rd_bank_reg;
  logic [1:0]        full_reg, full_next;
  rd_state_t         state_reg, state_next;
  logic [RW-1:0]     rd_row_reg;
  logic [AW-1:0]     rd_word_reg;
  logic [BW-1:0]     rd_beat_reg;
  logic              sof_pend_reg;
  logic              pipe_vld_reg, pipe_sof_reg, pipe_eol_reg;
  logic [RW-1:0]     pipe_row_reg;
  logic [BW-1:0]     pipe_beat_reg;
  logic [WORD_W-1:0] rd_word_all [BLK_H];
  logic [WORD_W-1:0] pipe_word;
  logic [BEAT_W-1:0] pipe_beat_data;
  logic [BEAT_W-1:0] skid_data_reg [2];
  logic [1:0]        skid_sof_reg, skid_eol_reg, skid_cnt_reg, occ;
  logic              skid_wr_reg, skid_rd_reg;
  logic              in_fire, fill_done, pop, room, issue, drained;
  logic              last_word, word_end, row_end, final_beat;

  assign bus.in_ready  = started_reg & ~bus.sof & ~full_reg[wr_bank_reg];
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign fill_done     = in_fire & (blk_cnt_reg == last_blk_reg);
  assign bus.out_valid = (skid_cnt_reg != 2'd0);
  assign bus.out_data  = skid_data_reg[skid_rd_reg];
  assign bus.out_sof   = bus.out_valid & skid_sof_reg[skid_rd_reg];
  assign bus.out_eol   = bus.out_valid & skid_eol_reg[skid_rd_reg];
  assign pop           = bus.out_valid & bus.out_ready;

  // Credit check: beats in flight from the RAM plus skid entries never exceed 2.
  assign occ  = skid_cnt_reg + {1'b0, pipe_vld_reg};
  assign room = (occ != 2'd2) | pop;

  // Raster walk position: last word of a row carries only last_beats beats.
  assign last_word  = (rd_word_reg == last_blk_reg);
  assign word_end   = last_word ? (rd_beat_reg == last_beat_reg) : (rd_beat_reg == BW'(BPW - 1));
  assign row_end    = last_word & word_end;
  assign final_beat = row_end & (rd_row_reg == RW'(BLK_H - 1));

  // Slice geometry derived from the width presented with sof.
  always_comb begin
    last_blk_next  = AW'((int'(bus.slice_width) + BLK_W - 1) / BLK_W - 1);
    last_beat_next = BW'(((int'(bus.slice_width) - 1) % BLK_W) / OUT_PIX);
  end

  // Read FSM next state; IDLE issues the first read itself to save a cycle.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    drained    = 1'b0;
    case (state_reg)
      IDLE: if (full_reg[rd_bank_reg] & room) begin
        issue      = 1'b1;
        state_next = final_beat ? DONE : READ;
      end
      READ: if (room) begin
        issue = 1'b1;
        if (final_beat) state_next = DONE;
      end
      DONE: if ((occ == 2'd1) & pop) begin
        drained    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill and drain update their own bank's flag independently.
  always_comb begin
    full_next = full_reg;
    if (fill_done) full_next[wr_bank_reg] = 1'b1;
    if (drained)   full_next[rd_bank_reg] = 1'b0;
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.sof) state_reg <= IDLE;
    else                   state_reg <= state_next;
  end

  // Slice control, write pointer and bank flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started_reg   <= 1'b0;
      last_blk_reg  <= '0;
      last_beat_reg <= '0;
      blk_cnt_reg   <= '0;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      full_reg      <= 2'b00;
    end else if (bus.sof) begin
      started_reg   <= 1'b1;
      last_blk_reg  <= last_blk_next;
      last_beat_reg <= last_beat_next;
      blk_cnt_reg   <= '0;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      full_reg      <= 2'b00;
    end else begin
      if (fill_done) begin
        blk_cnt_reg <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else if (in_fire) begin
        blk_cnt_reg <= blk_cnt_reg + AW'(1);
      end
      if (drained) rd_bank_reg <= ~rd_bank_reg;
      full_reg <= full_next;
    end
  end

  // Read pointer walk: beat within word, word within row, row within bank.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.sof || (issue && final_beat)) begin
      rd_row_reg  <= '0;
      rd_word_reg <= '0;
      rd_beat_reg <= '0;
    end else if (issue) begin
      if (row_end) begin
        rd_row_reg  <= rd_row_reg + RW'(1);
        rd_word_reg <= '0;
        rd_beat_reg <= '0;
      end else if (word_end) begin
        rd_word_reg <= rd_word_reg + AW'(1);
        rd_beat_reg <= '0;
      end else begin
        rd_beat_reg <= rd_beat_reg + BW'(1);
      end
    end
  end

  // Row RAMs: input layout is component-major, stored pixel-major per word.
  for (genvar gi = 0; gi < BLK_H; gi++) begin : g_row
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] ram_q;
    logic [WORD_W-1:0] mem [2**(AW+1)];
    for (genvar gj = 0; gj < BLK_W; gj++) begin : g_col
      for (genvar gk = 0; gk < NUM_CP; gk++) begin : g_cp
        assign wr_word[(gj*NUM_CP+gk)*BPC +: BPC] = bus.in_data[((gk*BLK_H+gi)*BLK_W+gj)*BPC +: BPC];
      end
    end
    // Write port fills one bank, registered read port drains the other.
    always_ff @(posedge clk) begin
      if (in_fire) mem[{wr_bank_reg, blk_cnt_reg}] <= wr_word;
      if (issue)   ram_q <= mem[{rd_bank_reg, rd_word_reg}];
    end
    assign rd_word_all[gi] = ram_q;
  end

  assign pipe_word      = rd_word_all[pipe_row_reg];
  assign pipe_beat_data = pipe_word[pipe_beat_reg*BEAT_W +: BEAT_W];

  // Tags travelling alongside the RAM read; sof marks the first beat read.
  always_ff @(posedge clk) begin
    if (!rst_n)       sof_pend_reg <= 1'b0;
    else if (bus.sof) sof_pend_reg <= 1'b1;
    else if (issue)   sof_pend_reg <= 1'b0;
    if (!rst_n || bus.sof) begin
      pipe_vld_reg  <= 1'b0;
      pipe_row_reg  <= '0;
      pipe_beat_reg <= '0;
      pipe_sof_reg  <= 1'b0;
      pipe_eol_reg  <= 1'b0;
    end else begin
      pipe_vld_reg <= issue;
      if (issue) begin
        pipe_row_reg  <= rd_row_reg;
        pipe_beat_reg <= rd_beat_reg;
        pipe_sof_reg  <= sof_pend_reg;
        pipe_eol_reg  <= row_end;
      end
    end
  end

  // Two-entry skid FIFO holding output beats stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.sof) begin
      skid_data_reg[0] <= '0;
      skid_data_reg[1] <= '0;
      skid_sof_reg     <= 2'b00;
      skid_eol_reg     <= 2'b00;
      skid_wr_reg      <= 1'b0;
      skid_rd_reg      <= 1'b0;
      skid_cnt_reg     <= 2'd0;
    end else begin
      if (pipe_vld_reg) begin
        skid_data_reg[skid_wr_reg] <= pipe_beat_data;
        skid_sof_reg[skid_wr_reg]  <= pipe_sof_reg;
        skid_eol_reg[skid_wr_reg]  <= pipe_eol_reg;
        skid_wr_reg                <= ~skid_wr_reg;
      end
      if (pop) skid_rd_reg <= ~skid_rd_reg;
      skid_cnt_reg <= skid_cnt_reg + {1'b0, pipe_vld_reg} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_raster_block_reorder.sv
// Randomized bench for raster_block_reorder: a raster-order reference model
// computes every expected beat directly from pixel coordinates.
module tb_raster_block_reorder;
  localparam int MAX_SLICE_WIDTH = 2560;
  localparam int BLK_H   = 2;
  localparam int BLK_W   = 8;
  localparam int NUM_CP  = 3;
  localparam int BPC     = 14;
  localparam int OUT_PIX = 4;
  localparam int WW      = $clog2(MAX_SLICE_WIDTH + 1);
  localparam int IN_W    = NUM_CP * BLK_H * BLK_W * BPC;
  localparam int OUT_W   = OUT_PIX * NUM_CP * BPC;
  localparam int BUDGET  = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raster_block_reorder_if #(
    .MAX_SLICE_WIDTH(MAX_SLICE_WIDTH), .BLK_H(BLK_H), .BLK_W(BLK_W),
    .NUM_CP(NUM_CP), .BPC(BPC), .OUT_PIX(OUT_PIX)
  ) bus ();

  raster_block_reorder #(
    .MAX_SLICE_WIDTH(MAX_SLICE_WIDTH), .BLK_H(BLK_H), .BLK_W(BLK_W),
    .NUM_CP(NUM_CP), .BPC(BPC), .OUT_PIX(OUT_PIX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel value at block-row br, row r, column x, component cp.
  function automatic logic [BPC-1:0] pix(int seed, int br, int r, int x, int cp);
    int v;
    v = (x + 100*r + 1000*cp + 3000*br + 7*seed) % 16384;
    return v[BPC-1:0];
  endfunction

  function automatic logic [IN_W-1:0] make_block(int seed, int br, int blk);
    logic [IN_W-1:0] d;
    d = '0;
    for (int cp = 0; cp < NUM_CP; cp++)
      for (int r = 0; r < BLK_H; r++)
        for (int c = 0; c < BLK_W; c++)
          d[((cp*BLK_H+r)*BLK_W+c)*BPC +: BPC] = pix(seed, br, r, blk*BLK_W + c, cp);
    return d;
  endfunction

  function automatic logic [OUT_W-1:0] exp_beat(int seed, int br, int r, int x);
    logic [OUT_W-1:0] d;
    d = '0;
    for (int p = 0; p < OUT_PIX; p++)
      for (int cp = 0; cp < NUM_CP; cp++)
        d[(p*NUM_CP+cp)*BPC +: BPC] = pix(seed, br, r, x + p, cp);
    return d;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 256'(bus.out_valid), 256'(0));
    check_eq({tag, "_out_sof"},   256'(bus.out_sof),   256'(0));
    check_eq({tag, "_out_eol"},   256'(bus.out_eol),   256'(0));
    check_eq({tag, "_out_data"},  256'(bus.out_data),  256'(0));
    check_eq({tag, "_in_ready"},  256'(bus.in_ready),  256'(0));
  endtask

  // sof cycle presents a junk block, which must not be taken.
  task automatic start_slice(input int w);
    @(negedge clk);
    bus.sof         = 1'b1;
    bus.slice_width = WW'(w);
    bus.in_valid    = 1'b1;
    bus.in_data     = make_block(4321, 7, 7);
    bus.out_ready   = 1'b1;
    #1;
    check_eq("sof_in_ready", 256'(bus.in_ready), 256'(0));
    @(negedge clk);
    bus.sof      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("post_sof_in_ready", 256'(bus.in_ready), 256'(1));
    check_eq("post_sof_out_valid", 256'(bus.out_valid), 256'(0));
  endtask

  task automatic run_slice(input int w, input int nbr, input int seed,
                           input int out_pct, input int in_pct, input int stop_beats);
    int blks, p_br, p_blk, c_br, c_r, c_x, nbeats, filled, drained, cyc;
    int fill_cyc, first_vld_cyc;
    bit in_hold, in_fire, out_fire, last_of_br, prev_stall, prev_fire, prev_last;
    logic [OUT_W-1:0] prev_data;
    blks = (w + BLK_W - 1) / BLK_W;
    p_br = 0; p_blk = 0; c_br = 0; c_r = 0; c_x = 0; nbeats = 0;
    filled = 0; drained = 0; cyc = 0; fill_cyc = -1; first_vld_cyc = -1;
    in_hold = 0; prev_stall = 0; prev_fire = 0; prev_last = 0; prev_data = '0;
    while (c_br < nbr && !(stop_beats > 0 && nbeats >= stop_beats) && cyc < BUDGET) begin
      @(negedge clk);
      if (!in_hold) bus.in_valid = (p_br < nbr) && ($urandom_range(99) < in_pct);
      bus.in_data   = make_block(seed, p_br, p_blk);
      bus.out_ready = ($urandom_range(99) < out_pct);
      #1;
      if (first_vld_cyc < 0 && bus.out_valid) first_vld_cyc = cyc;
      if (prev_stall) begin
        check_eq("stall_valid", 256'(bus.out_valid), 256'(1));
        check_eq("stall_data", 256'(bus.out_data), 256'(prev_data));
      end
      if (out_pct == 100 && prev_fire && !prev_last)
        check_eq("no_bubble", 256'(bus.out_valid), 256'(1));
      check_eq("in_ready", 256'(bus.in_ready), 256'((filled - drained) < 2));
      in_fire  = bus.in_valid & bus.in_ready;
      out_fire = bus.out_valid & bus.out_ready;
      last_of_br = 0;
      if (out_fire) begin
        check_eq("beat_data", 256'(bus.out_data), 256'(exp_beat(seed, c_br, c_r, c_x)));
        check_eq("beat_sof", 256'(bus.out_sof), 256'(c_br == 0 && c_r == 0 && c_x == 0));
        check_eq("beat_eol", 256'(bus.out_eol), 256'(c_x + OUT_PIX == w));
        nbeats++;
        c_x += OUT_PIX;
        if (c_x >= w) begin
          c_x = 0;
          c_r++;
          if (c_r == BLK_H) begin
            c_r = 0;
            c_br++;
            drained++;
            last_of_br = 1;
          end
        end
      end
      if (in_fire) begin
        if (p_blk == blks - 1) begin
          p_blk = 0;
          p_br++;
          filled++;
          if (filled == 1) fill_cyc = cyc;
        end else begin
          p_blk++;
        end
      end
      in_hold    = bus.in_valid & ~bus.in_ready;
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      prev_fire  = out_fire;
      prev_last  = last_of_br;
      cyc++;
    end
    if (cyc >= BUDGET) check_eq("timeout", 256'(cyc), 256'(0));
    if (fill_cyc >= 0 && first_vld_cyc >= 0)
      check_eq("latency", 256'(first_vld_cyc - fill_cyc), 256'(3));
    $display("[TB] slice w=%0d blockrows=%0d beats=%0d cycles=%0d", w, nbr, nbeats, cyc);
  endtask

  initial begin
    int w, nbr;
    bus.sof = 1'b0; bus.slice_width = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_sof_in_ready", 256'(bus.in_ready), 256'(0));

    // basic order, partial last block, backpressure, sustained rate
    start_slice(16);   run_slice(16, 1, 0, 100, 100, 0);
    start_slice(20);   run_slice(20, 1, $urandom_range(1, 500), 100, 100, 0);
    start_slice(16);   run_slice(16, 4, $urandom_range(1, 500), 30, 100, 0);
    start_slice(2560); run_slice(2560, 2, $urandom_range(1, 500), 100, 100, 0);

    // sof in mid-drain, then a fresh slice with new data
    start_slice(16);   run_slice(16, 2, 11, 100, 100, 3);
    start_slice(16);   run_slice(16, 1, 222, 100, 100, 0);

    // one-cycle reset in mid-drain
    start_slice(24);   run_slice(24, 3, 33, 50, 100, 5);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    #1;
    check_eq("post_reset_in_ready", 256'(bus.in_ready), 256'(0));
    start_slice(24);   run_slice(24, 2, 44, 100, 100, 0);

    // random geometry and handshake patterns
    for (int t = 0; t < 6; t++) begin
      w   = OUT_PIX * $urandom_range(1, 48);
      nbr = $urandom_range(1, 4);
      start_slice(w);
      run_slice(w, nbr, $urandom_range(1, 1000), $urandom_range(20, 100), $urandom_range(30, 100), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
